// File: rtl/drive_z_corr_table_loader_if.sv
// Host-stream and table-write signal bundle for drive_z_corr_table_loader.
// The loader connects through the slave modport; the host/table side uses master.
interface drive_z_corr_table_loader_if #(
    parameter int NUM_BANK   = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 4
);
    logic                  start;
    logic                  in_valid;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_ready;
    logic [NUM_BANK-1:0]   z_corr_memory_wr_sel;
    logic                  z_corr_memory_wr_en;
    logic [ADDR_WIDTH-1:0] z_corr_memory_wr_addr;
    logic [DATA_WIDTH-1:0] z_corr_memory_wr_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, z_corr_memory_wr_sel, z_corr_memory_wr_en,
        input  z_corr_memory_wr_addr, z_corr_memory_wr_data, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, z_corr_memory_wr_sel, z_corr_memory_wr_en,
        output z_corr_memory_wr_addr, z_corr_memory_wr_data, busy, done
    );
endinterface

// File: rtl/drive_z_corr_table_loader.sv
// Packs narrow host beats into z-correction table words and writes every entry of
// every bank in bank-major order; all outputs come straight from flops.
module drive_z_corr_table_loader #(
    parameter int NUM_BANK                  = 2,
    parameter int NUM_QUBIT_PER_BANK        = 2,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 1,
    parameter int Z_CORR_WIDTH              = 4,
    parameter int IN_WIDTH                  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    drive_z_corr_table_loader_if.slave   bus_if
);
    localparam int NUM_ENTRY  = NUM_QUBIT_PER_BANK;
    localparam int ADDR_WIDTH = QUBIT_ADDR_WIDTH_PER_BANK;
    localparam int DATA_WIDTH = Z_CORR_WIDTH * NUM_QUBIT_PER_BANK * NUM_BANK;
    localparam int BEATS      = DATA_WIDTH / IN_WIDTH;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BANK_W     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] entry_idx_q, entry_idx_d;
    logic [BANK_W-1:0]     bank_idx_q, bank_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_en_q, wr_en_d;
    logic [NUM_BANK-1:0]   wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic beat_fire;
    logic last_beat;
    logic last_entry;
    logic last_bank;

    // in_ready_q is only ever set for COLLECT, so it already qualifies the handshake.
    assign beat_fire  = (state_q == ST_COLLECT) && bus_if.in_valid && in_ready_q;
    assign last_beat  = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign last_entry = (entry_idx_q == ADDR_WIDTH'(NUM_ENTRY - 1));
    assign last_bank  = (bank_idx_q == BANK_W'(NUM_BANK - 1));

    // Outputs are computed for the state being entered, so they line up with it once registered.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        entry_idx_d = entry_idx_q;
        bank_idx_d  = bank_idx_q;
        word_d      = word_q;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_sel_d    = '0;
        wr_addr_d   = '0;
        wr_data_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    state_d     = ST_COLLECT;
                    beat_cnt_d  = '0;
                    entry_idx_d = '0;
                    bank_idx_d  = '0;
                    word_d      = '0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_COLLECT: begin
                busy_d     = 1'b1;
                in_ready_d = 1'b1;
                if (beat_fire) begin
                    word_d[int'(beat_cnt_q) * IN_WIDTH +: IN_WIDTH] = bus_if.in_data;
                    if (last_beat) begin
                        state_d    = ST_WRITE;
                        beat_cnt_d = '0;
                        in_ready_d = 1'b0;
                        wr_en_d    = 1'b1;
                        wr_sel_d   = NUM_BANK'(1) << bank_idx_q;
                        wr_addr_d  = entry_idx_q;
                        wr_data_d  = word_d;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                busy_d = 1'b1;
                word_d = '0;
                if (last_entry && last_bank) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_COLLECT;
                    in_ready_d = 1'b1;
                    if (last_entry) begin
                        entry_idx_d = '0;
                        bank_idx_d  = bank_idx_q + 1'b1;
                    end else begin
                        entry_idx_d = entry_idx_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            entry_idx_q <= '0;
            bank_idx_q  <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            entry_idx_q <= entry_idx_d;
            bank_idx_q  <= bank_idx_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus_if.in_ready              = in_ready_q;
    assign bus_if.busy                  = busy_q;
    assign bus_if.done                  = done_q;
    assign bus_if.z_corr_memory_wr_en   = wr_en_q;
    assign bus_if.z_corr_memory_wr_sel  = wr_sel_q;
    assign bus_if.z_corr_memory_wr_addr = wr_addr_q;
    assign bus_if.z_corr_memory_wr_data = wr_data_q;
endmodule

// File: tb/tb_drive_z_corr_table_loader.sv
// Bench for drive_z_corr_table_loader: vector table of words and expected writes, with a
// scoreboard queue popped by a negedge monitor whenever the table write strobe fires.
module tb_drive_z_corr_table_loader;
    localparam int NUM_BANK   = 2;
    localparam int ADDR_WIDTH = 1;
    localparam int DATA_WIDTH = 16;
    localparam int IN_WIDTH   = 4;
    localparam int BEATS      = 4;
    localparam int NUM_WORDS  = 4;

    typedef struct packed {
        logic [BEATS-1:0][IN_WIDTH-1:0] beats;
        logic [NUM_BANK-1:0]            sel;
        logic [ADDR_WIDTH-1:0]          addr;
        logic [DATA_WIDTH-1:0]          data;
    } vec_t;

    typedef struct packed {
        logic [NUM_BANK-1:0]   sel;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   wr_cyc [8];
    logic prev_wr_en = 1'b0;
    logic prev_done = 1'b0;
    vec_t vecs [NUM_WORDS];
    wr_t  exp_q [$];

    drive_z_corr_table_loader_if #(
        .NUM_BANK(NUM_BANK), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .IN_WIDTH(IN_WIDTH)
    ) bus ();

    drive_z_corr_table_loader dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.z_corr_memory_wr_en) begin
            check("wr_one_cycle", {31'd0, prev_wr_en}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_sel", {30'd0, bus.z_corr_memory_wr_sel}, {30'd0, e.sel});
                check("wr_addr", {31'd0, bus.z_corr_memory_wr_addr}, {31'd0, e.addr});
                check("wr_data", {16'd0, bus.z_corr_memory_wr_data}, {16'd0, e.data});
            end
            if (wr_count < 8) wr_cyc[wr_count] = cyc;
            wr_count++;
        end else begin
            check("idle_wr_bus", {13'd0, bus.z_corr_memory_wr_sel, bus.z_corr_memory_wr_addr,
                                  bus.z_corr_memory_wr_data}, 32'd0);
        end
        if (bus.done) begin
            check("done_flags", {29'd0, bus.busy, bus.in_ready, prev_done}, 32'b100);
            done_cnt++;
            done_cyc = cyc;
        end
        prev_wr_en = bus.z_corr_memory_wr_en;
        prev_done  = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_WIDTH-1:0] d);
        logic rdy;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        check("beat_accepted", {31'd0, rdy}, 32'd1);
    endtask

    // The expectation is pushed once the final beat is in, so an early write finds an empty queue.
    task automatic send_word(input int w, input bit bubble);
        for (int b = 0; b < BEATS; b++) begin
            if (bubble) begin
                bus.in_valid = 1'b0;
                tick();
            end
            send_beat(vecs[w].beats[b]);
        end
        exp_q.push_back('{sel: vecs[w].sel, addr: vecs[w].addr, data: vecs[w].data});
    endtask

    task automatic pulse_start(input bit with_beat);
        bus.start = 1'b1;
        if (with_beat) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'hF;
        end
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input bit bubble, input bit mid_start, input bit beat_at_start);
        int n;
        wr_count = 0;
        done_cnt = 0;
        tick();
        pulse_start(beat_at_start);
        for (int w = 0; w < NUM_WORDS; w++) begin
            send_word(w, bubble);
            if (mid_start && w == 1) begin
                bus.in_valid = 1'b0;
                tick();
                pulse_start(1'b0);
            end
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
        repeat (4) tick();
        check("write_count", wr_count, 32'd4);
        check("done_count", done_cnt, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        if (!bubble && !mid_start) begin
            for (int i = 1; i < NUM_WORDS; i++)
                check("write_spacing", wr_cyc[i] - wr_cyc[i-1], 32'd5);
            check("done_lag", done_cyc - wr_cyc[3], 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{beats: {4'h1, 4'h2, 4'h3, 4'h4}, sel: 2'b01, addr: 1'b0, data: 16'h1234};
        vecs[1] = '{beats: {4'h8, 4'h8, 4'h8, 4'h8}, sel: 2'b01, addr: 1'b1, data: 16'h8888};
        vecs[2] = '{beats: {4'h9, 4'h9, 4'h9, 4'h9}, sel: 2'b10, addr: 1'b0, data: 16'h9999};
        vecs[3] = '{beats: {4'h2, 4'h2, 4'h2, 4'h2}, sel: 2'b10, addr: 1'b1, data: 16'h2222};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        check("reset_outputs", {12'd0, bus.in_ready, bus.busy, bus.done, bus.z_corr_memory_wr_en,
                                bus.z_corr_memory_wr_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full load with in_valid held high.
        run_load(1'b0, 1'b0, 1'b0);

        // Same data with a bubble before every beat.
        run_load(1'b1, 1'b0, 1'b0);

        // Second start after the 2nd write must be ignored.
        run_load(1'b0, 1'b1, 1'b0);

        // Reset after two beats of word 2 aborts the load.
        wr_count = 0;
        tick();
        pulse_start(1'b0);
        send_word(0, 1'b0);
        send_beat(vecs[1].beats[0]);
        send_beat(vecs[1].beats[1]);
        rst = 1'b0;
        #1;
        check("abort_busy_ready", {30'd0, bus.busy, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_wr_en", {31'd0, bus.z_corr_memory_wr_en}, 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_one_write", wr_count, 32'd1);
        check("abort_queue", exp_q.size(), 32'd0);
        run_load(1'b0, 1'b0, 1'b0);

        // in_valid high in IDLE without start, then a beat alongside start.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h7;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_no_ready", {30'd0, bus.in_ready, bus.busy}, 32'd0);
        end
        bus.in_valid = 1'b0;
        check("idle_no_writes", wr_count, 32'd4);
        run_load(1'b0, 1'b0, 1'b1);

        // Write bus stays quiet after done until the next start.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_done_idle", {13'd0, bus.z_corr_memory_wr_en, bus.z_corr_memory_wr_sel,
                                     bus.z_corr_memory_wr_data}, 32'd0);
            check("post_done_busy", {29'd0, bus.busy, bus.done, bus.z_corr_memory_wr_addr}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
